// File: rtl/acc_muldiv_unit_if.sv
// Bundle between the multicycle controller / accumulator file and the mul/div unit.
// The controller side drives the request; the unit drives status and the write port.
interface acc_muldiv_unit_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       dst_lo;
    logic [1:0]       dst_hi;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic             AcWen;
    logic [1:0]       WrAdr;
    logic [WIDTH-1:0] WrData;

    modport master (
        output start, op, a, b, dst_lo, dst_hi,
        input  busy, done, div_zero, AcWen, WrAdr, WrData
    );

    modport slave (
        input  start, op, a, b, dst_lo, dst_hi,
        output busy, done, div_zero, AcWen, WrAdr, WrData
    );
endinterface

// File: rtl/acc_muldiv_unit.sv
// Iterative unsigned WIDTH x WIDTH shift-add multiplier / restoring divider that
// writes its two result bytes back into the accumulator file over two cycles.
module acc_muldiv_unit #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    acc_muldiv_unit_if.slave   bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CALC  = 2'd1;
    localparam logic [1:0] WR_LO = 2'd2;
    localparam logic [1:0] WR_HI = 2'd3;

    logic [1:0]       state_r;
    logic [CW-1:0]    cnt_r;
    logic             op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [1:0]       dst_lo_r;
    logic [1:0]       dst_hi_r;
    // hi_r: upper product half (mul) or WIDTH+1-bit partial remainder (div)
    // lo_r: multiplier being shifted out (mul) or dividend/quotient shift register (div)
    logic [WIDTH:0]   hi_r;
    logic [WIDTH-1:0] lo_r;

    logic             busy_r;
    logic             done_r;
    logic             div_zero_r;
    logic             ac_wen_r;
    logic [1:0]       wr_adr_r;
    logic [WIDTH-1:0] wr_data_r;

    logic [WIDTH+1:0] mul_sum_s;
    logic [WIDTH+1:0] div_shift_s;
    logic [WIDTH+1:0] div_diff_s;
    logic [WIDTH:0]   hi_nxt_s;
    logic [WIDTH-1:0] lo_nxt_s;

    // One iteration of the selected algorithm; the top bit of div_diff_s is the trial-subtract borrow.
    always_comb begin
        mul_sum_s   = {1'b0, hi_r} + {2'b00, (lo_r[0] ? a_r : {WIDTH{1'b0}})};
        div_shift_s = {hi_r, lo_r[WIDTH-1]};
        div_diff_s  = div_shift_s - {2'b00, b_r};
        if (op_r) begin
            hi_nxt_s = div_diff_s[WIDTH+1] ? div_shift_s[WIDTH:0] : div_diff_s[WIDTH:0];
            lo_nxt_s = {lo_r[WIDTH-2:0], ~div_diff_s[WIDTH+1]};
        end else begin
            hi_nxt_s = mul_sum_s[WIDTH+1:1];
            lo_nxt_s = {mul_sum_s[0], lo_r[WIDTH-1:1]};
        end
    end

    // Sequencer, datapath registers and registered write-port outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= {CW{1'b0}};
            op_r       <= 1'b0;
            a_r        <= {WIDTH{1'b0}};
            b_r        <= {WIDTH{1'b0}};
            dst_lo_r   <= 2'd0;
            dst_hi_r   <= 2'd0;
            hi_r       <= {(WIDTH+1){1'b0}};
            lo_r       <= {WIDTH{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            div_zero_r <= 1'b0;
            ac_wen_r   <= 1'b0;
            wr_adr_r   <= 2'd0;
            wr_data_r  <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        op_r       <= bus.op;
                        a_r        <= bus.a;
                        b_r        <= bus.b;
                        dst_lo_r   <= bus.dst_lo;
                        dst_hi_r   <= bus.dst_hi;
                        hi_r       <= {(WIDTH+1){1'b0}};
                        lo_r       <= bus.op ? bus.a : bus.b;
                        cnt_r      <= CW'(WIDTH - 1);
                        div_zero_r <= bus.op & (bus.b == {WIDTH{1'b0}});
                        busy_r     <= 1'b1;
                        state_r    <= CALC;
                    end
                end
                CALC: begin
                    hi_r <= hi_nxt_s;
                    lo_r <= lo_nxt_s;
                    if (cnt_r == {CW{1'b0}}) begin
                        // The last iteration lands in the same edge, so forward its low result.
                        state_r   <= WR_LO;
                        ac_wen_r  <= 1'b1;
                        wr_adr_r  <= dst_lo_r;
                        wr_data_r <= lo_nxt_s;
                    end else begin
                        cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                WR_LO: begin
                    state_r   <= WR_HI;
                    wr_adr_r  <= dst_hi_r;
                    wr_data_r <= hi_r[WIDTH-1:0];
                    done_r    <= 1'b1;
                end
                WR_HI: begin
                    state_r   <= IDLE;
                    busy_r    <= 1'b0;
                    done_r    <= 1'b0;
                    ac_wen_r  <= 1'b0;
                    wr_adr_r  <= 2'd0;
                    wr_data_r <= {WIDTH{1'b0}};
                end
                default: begin
                    state_r   <= IDLE;
                    busy_r    <= 1'b0;
                    done_r    <= 1'b0;
                    ac_wen_r  <= 1'b0;
                    wr_adr_r  <= 2'd0;
                    wr_data_r <= {WIDTH{1'b0}};
                end
            endcase
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.div_zero = div_zero_r;
    assign bus.AcWen    = ac_wen_r;
    assign bus.WrAdr    = wr_adr_r;
    assign bus.WrData   = wr_data_r;
endmodule

// File: doc/acc_muldiv_unit.md
# acc_muldiv_unit

Iterative unsigned 8×8 multiply / 8÷8 divide unit sitting beside the accumulator register file in the multicycle datapath. It consumes the two accumulator read values as operands and writes its two result bytes back into the file through that file's write port (AcWen/WrAdr/WrData). The controller triggers it with a one-cycle `start` and stalls while `busy` is high.

## Interface
- WIDTH, 8, operand/result byte width; the iteration count equals WIDTH
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request; accepted only when sampled at an edge with busy=0
- op  in  1  0 = multiply, 1 = divide
- a  in  WIDTH  operand A (multiplicand / dividend), from accumulator read port 1
- b  in  WIDTH  operand B (multiplier / divisor), from accumulator read port 2
- dst_lo  in  2  accumulator index for low result (product[7:0] / quotient)
- dst_hi  in  2  accumulator index for high result (product[15:8] / remainder)
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse during the final write cycle
- div_zero  out  1  last accepted op was a divide with b=0
- AcWen  out  1  accumulator write enable
- WrAdr  out  2  accumulator write index
- WrData  out  WIDTH  accumulator write data

## Operation
- States: IDLE, CALC, WR_LO, WR_HI.
- IDLE + start sampled: latch a, b, op, dst_lo, dst_hi; clear the working registers; load the iteration counter with WIDTH-1; set div_zero = op & (b==0); go to CALC.
- CALC, multiply: radix-2 shift-add; 2·WIDTH-bit product, one multiplier bit per cycle, LSB first.
- CALC, divide: restoring division, one quotient bit per cycle, MSB first; remainder register is WIDTH+1 bits so the trial subtract never loses a borrow.
- CALC lasts exactly WIDTH cycles; the counter decrements and CALC goes to WR_LO after the cycle in which the counter is 0.
- WR_LO: AcWen=1, WrAdr=dst_lo, WrData = product[7:0] or quotient.
- WR_HI: AcWen=1, WrAdr=dst_hi, WrData = product[15:8] or remainder, done=1. Then go to IDLE.
- Divide by zero: no shortcut; the latency is unchanged. The algorithm naturally yields quotient = all ones and remainder = a, and div_zero=1.
- dst_lo == dst_hi: both writes are issued; the WR_HI value is the one that remains.
- start while busy=1, including during WR_HI, is ignored; there is no queueing.
- div_zero holds its value until the next accepted start.
- Outside WR_LO/WR_HI: AcWen=0, WrAdr=0, WrData=0.

## Timing
- Cycle n is the clock period following rising edge n; start is accepted at edge 0.
- Cycles 0–7: CALC, busy=1.
- Cycle 8: WR_LO. The accumulator file captures it at edge 9.
- Cycle 9: WR_HI, done=1. Captured at edge 10.
- Cycle 10: IDLE, busy=0. The earliest next accepted start is at edge 11.
- Latency is fixed at 10 cycles from acceptance to the last write, for both ops and all operand values.
- Reset values: busy=0, done=0, div_zero=0, AcWen=0, WrAdr=0, WrData=0, state=IDLE.
- Reset mid-operation takes effect asynchronously. Outputs drop immediately and no further write is issued. A WR_LO already captured by the file stays in the file.
- AcWen, WrAdr, WrData and done are decoded from registered state only and never depend combinationally on start, a or b.

## Test plan
- Multiply: a=8'hFF, b=8'hFF, dst_lo=0, dst_hi=1 -> cycle 8 writes 8'h01 to index 0; cycle 9 writes 8'hFE to index 1 with done=1; busy low in cycle 10.
- Divide: a=200, b=7, dst_lo=2, dst_hi=3 -> 8'h1C written to index 2, 8'h04 written to index 3, div_zero=0.
- Divide by zero: a=8'h5A, b=0 -> 8'hFF then 8'h5A written at the normal cycles 8 and 9; div_zero=1 until the next accepted start.
- start re-pulsed in cycles 3 and 9 with different operands -> both ignored; the results match the first operands; exactly two AcWen pulses.
- rst asserted mid-cycle 4 -> busy, AcWen and done go 0 at once; no writes follow; a fresh start afterwards gives a correct 10-cycle result.
- a=8'h10, b=8'h10, multiply, dst_lo=dst_hi=2 -> writes 8'h00 then 8'h01 to index 2; the final content is 8'h01.
